// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Goldschmidt divider controller: FSM states, operand-select
// encodings and the default refinement iteration count.
package fpdiv_pkg;

    localparam int unsigned NiterDefault = 3;

    typedef enum logic [2:0] {
        StIdle,
        StIaA,
        StIaB,
        StItA,
        StItB,
        StRem,
        StDone
    } fpdiv_state_e;

    // Multiplier operand A select
    localparam logic [1:0] Mux3Ia    = 2'd0;
    localparam logic [1:0] Mux3Regc  = 2'd1;
    localparam logic [1:0] Mux3Denom = 2'd2;

    // Multiplier operand B select
    localparam logic [1:0] Mux4Num   = 2'd0;
    localparam logic [1:0] Mux4Denom = 2'd1;
    localparam logic [1:0] Mux4Rega  = 2'd2;
    localparam logic [1:0] Mux4Regb  = 2'd3;

    function automatic logic state_busy(fpdiv_state_e s);
        return (s != StIdle) && (s != StDone);
    endfunction

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Control bundle between a divider requester (master) and the fpdiv_ctrl sequencer (slave).
interface fpdiv_ctrl_if;

    logic       start;
    logic       rm_in;
    logic       flush;
    logic       en_a;
    logic       en_b;
    logic       en_rem;
    logic [1:0] sel_mux3;
    logic [1:0] sel_mux4;
    logic       rm;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output rm_in,
        output flush,
        input  en_a,
        input  en_b,
        input  en_rem,
        input  sel_mux3,
        input  sel_mux4,
        input  rm,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rm_in,
        input  flush,
        output en_a,
        output en_b,
        output en_rem,
        output sel_mux3,
        output sel_mux4,
        output rm,
        output busy,
        output done
    );

endinterface

// File: rtl/fpdiv_iter_cnt.sv
// 4-bit Goldschmidt iteration counter; last flags the final refinement pass.
module fpdiv_iter_cnt
    import fpdiv_pkg::*;
#(
    parameter int unsigned NITER = NiterDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic last
);

    localparam logic [3:0] LastCount = 4'(NITER - 1);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 4'd0;
        end else if (incr) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Exit is decided before the increment, so the count stops at NITER and never wraps.
    assign last = (count_q == LastCount);

endmodule

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for a Goldschmidt divider datapath. Define FPDIV_REM_EN to include the
// remainder (denom*q) pass before DONE.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int unsigned NITER = NiterDefault
) (
    input logic         clk,
    input logic         reset,
    fpdiv_ctrl_if.slave bus
);

    fpdiv_state_e state_q, state_d;
    logic         rm_q, rm_d;
    logic         cnt_clear;
    logic         cnt_incr;
    logic         cnt_last;

    logic         en_a;
    logic         en_b;
    logic [1:0]   sel_mux3;
    logic [1:0]   sel_mux4;
    logic         done;
`ifdef FPDIV_REM_EN
    logic         en_rem;
`endif

    fpdiv_iter_cnt #(
        .NITER (NITER)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        rm_d      = rm_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        if (bus.flush) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StIaA;
                        rm_d    = bus.rm_in;
                    end
                end
                StIaA: state_d = StIaB;
                StIaB: begin
                    state_d   = StItA;
                    cnt_clear = 1'b1;
                end
                StItA: state_d = StItB;
                StItB: begin
                    cnt_incr = 1'b1;
`ifdef FPDIV_REM_EN
                    state_d  = cnt_last ? StRem : StItA;
`else
                    state_d  = cnt_last ? StDone : StItA;
`endif
                end
`ifdef FPDIV_REM_EN
                StRem: state_d = StDone;
`endif
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rm_q    <= rm_d;
        end
    end

    // Outputs depend on the registered state only.
    always_comb begin
        en_a     = 1'b0;
        en_b     = 1'b0;
        sel_mux3 = Mux3Ia;
        sel_mux4 = Mux4Num;
        done     = 1'b0;
`ifdef FPDIV_REM_EN
        en_rem   = 1'b0;
`endif
        unique case (state_q)
            StIaA: en_a = 1'b1;
            StIaB: begin
                sel_mux4 = Mux4Denom;
                en_b     = 1'b1;
            end
            StItA: begin
                sel_mux3 = Mux3Regc;
                sel_mux4 = Mux4Rega;
                en_a     = 1'b1;
            end
            StItB: begin
                sel_mux3 = Mux3Regc;
                sel_mux4 = Mux4Regb;
                en_b     = 1'b1;
            end
`ifdef FPDIV_REM_EN
            StRem: begin
                sel_mux3 = Mux3Denom;
                sel_mux4 = Mux4Rega;
                en_rem   = 1'b1;
            end
`endif
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign bus.en_a     = en_a;
    assign bus.en_b     = en_b;
    assign bus.sel_mux3 = sel_mux3;
    assign bus.sel_mux4 = sel_mux4;
    assign bus.done     = done;
    assign bus.busy     = state_busy(state_q);
    assign bus.rm       = rm_q;
`ifdef FPDIV_REM_EN
    assign bus.en_rem   = en_rem;
`else
    assign bus.en_rem   = 1'b0;
`endif

    en_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({bus.en_a, bus.en_b, bus.en_rem}));

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Randomized bench for fpdiv_ctrl against a per-operation step-schedule reference model.
module tb_fpdiv_ctrl;

    localparam int unsigned NITER  = 3;
    localparam int unsigned NITER1 = 1;
`ifdef FPDIV_REM_EN
    localparam bit RemOn = 1'b1;
`else
    localparam bit RemOn = 1'b0;
`endif

    localparam int KindIdle = -1;
    localparam int KindIaA  = 0;
    localparam int KindIaB  = 1;
    localparam int KindItA  = 2;
    localparam int KindItB  = 3;
    localparam int KindRem  = 4;
    localparam int KindDone = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpdiv_ctrl_if bus ();
    fpdiv_ctrl_if bus1 ();

    assign bus1.start = bus.start;
    assign bus1.rm_in = bus.rm_in;
    assign bus1.flush = bus.flush;

    fpdiv_ctrl #(
        .NITER (NITER)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fpdiv_ctrl #(
        .NITER (NITER1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   sched[$];
    logic m_rm;
    int   m_itb;
    logic rem1_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4, rm}
    function automatic logic [9:0] exp_out(input int kind, input logic r);
        case (kind)
            KindIaA:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, r};
            KindIaB:  return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, r};
            KindItA:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, r};
            KindItB:  return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, r};
            KindRem:  return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, r};
            KindDone: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, r};
            default:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, r};
        endcase
    endfunction

    function automatic logic [9:0] act_out();
        return {bus.busy, bus.done, bus.en_a, bus.en_b, bus.en_rem,
                bus.sel_mux3, bus.sel_mux4, bus.rm};
    endfunction

    function automatic int cur_kind();
        return (sched.size() > 0) ? sched[0] : KindIdle;
    endfunction

    // Applies the inputs seen at a rising edge to the model.
    task automatic model_edge();
        if (bus.flush) begin
            sched.delete();
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
            if (sched.size() > 0 && sched[0] == KindItB) m_itb++;
        end else if (bus.start) begin
            sched.push_back(KindIaA);
            sched.push_back(KindIaB);
            for (int i = 0; i < int'(NITER); i++) begin
                sched.push_back(KindItA);
                sched.push_back(KindItB);
            end
            if (RemOn) sched.push_back(KindRem);
            sched.push_back(KindDone);
            m_rm  = bus.rm_in;
            m_itb = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("outs", 32'(act_out()), 32'(exp_out(cur_kind(), m_rm)));
        check("onehot", 32'($countones({bus.en_a, bus.en_b, bus.en_rem}) <= 1), 32'd1);
        check("onehot1", 32'($countones({bus1.en_a, bus1.en_b, bus1.en_rem}) <= 1), 32'd1);
        if (bus1.en_rem) rem1_seen = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // One request from idle; checks done latency on both instances.
    task automatic run_op(input logic r);
        int k;
        int k1;
        k  = 0;
        k1 = 0;
        bus.start = 1'b1;
        bus.rm_in = r;
        cycle();
        bus.start = 1'b0;
        bus.rm_in = ~r;
        for (int c = 1; c <= 60; c++) begin
            cycle();
            if (bus.done && k == 0) k = c;
            if (bus1.done && k1 == 0) k1 = c;
            if (k != 0 && k1 != 0) break;
        end
        check("latency", k, 2 * NITER + (RemOn ? 3 : 2));
        check("latency_n1", k1, 2 * NITER1 + (RemOn ? 3 : 2));
    endtask

    initial begin
        int done_c;
        int ia_c;
        bus.start = 1'b0;
        bus.rm_in = 1'b0;
        bus.flush = 1'b0;
        m_rm      = 1'b0;
        m_itb     = 0;
        rem1_seen = 1'b0;
        reset     = 1'b0;
        #12;
        check("reset", 32'(act_out()), 32'd0);
        check("reset1_busy", 32'(bus1.busy), 32'd0);
        reset = 1'b1;
        idle_cycles(2);

        // Basic runs in both rounding modes; rm must hold although rm_in toggles.
        run_op(1'b1);
        idle_cycles(3);
        run_op(1'b0);
        idle_cycles(3);

        // start held high: the request in DONE is ignored, next one taken from IDLE.
        done_c = 0;
        ia_c   = 0;
        bus.start = 1'b1;
        bus.rm_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (bus.done && done_c == 0) done_c = c;
            else if (done_c != 0 && ia_c == 0 && bus.en_a && bus.sel_mux3 == 2'd0) ia_c = c;
        end
        check("b2b_gap", ia_c - done_c, 2);
        idle_cycles(30);

        // flush during the second IT_B pass.
        bus.start = 1'b1;
        bus.rm_in = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (cur_kind() == KindItB && m_itb == 2) break;
            cycle();
        end
        check("flush_reach", 32'(bus.en_b && bus.sel_mux4 == 2'd3), 32'd1);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_rm", 32'(bus.rm), 32'd1);
        idle_cycles(12);
        run_op(1'b0);
        idle_cycles(3);

        // Asynchronous reset between edges during IT_A.
        bus.start = 1'b1;
        bus.rm_in = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (cur_kind() == KindItA) break;
            cycle();
        end
        check("arst_reach", 32'(bus.en_a && bus.sel_mux3 == 2'd1), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_outs", 32'(act_out()), 32'd0);
        check("arst_outs1", 32'(bus1.busy), 32'd0);
        sched.delete();
        m_rm = 1'b0;
        #1;
        reset = 1'b1;
        idle_cycles(3);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.rm_in = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_cycles(30);

        // Final guaranteed full run: the NITER=1 instance goes through REM only if enabled.
        run_op(1'b1);
        idle_cycles(3);
        check("rem1_seen", 32'(rem1_seen), 32'(RemOn));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
